// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with anode dead time,
// frame-synchronous double-buffered value loading and leading-zero blanking.
module sseg_scan_driver #(
    parameter int DEADTIME = 4,
    parameter bit LZ_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  anode_index,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_dp,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int            CW       = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DEADTIME);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q;

    logic [15:0]   shadow_data_q, active_data_q, active_data_d;
    logic [3:0]    shadow_dp_q, active_dp_q, active_dp_d;
    logic          pending_q;

    logic          change, boundary, accept, show;
    logic [3:0]    nibble, nib_zero;
    logic          dp_bit, lz_hit;
    logic [3:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign change     = (anode_index != idx_q);
    assign boundary   = change && (idx_q == 2'd0) && (anode_index == 2'd3);
    assign load_ready = !pending_q;
    assign accept     = load_valid && !pending_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= CNT_INIT;
            idx_q   <= 2'b11;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= anode_index;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (change) begin
            state_d = BLANK;
            cnt_d   = CNT_INIT;
        end else if (state_q == BLANK) begin
            if (cnt_q == '0) begin
                state_d = DRIVE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // Shadow is only written while free, so a transfer and a new accept never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            active_data_q <= '0;
            active_dp_q   <= '0;
            pending_q     <= 1'b0;
        end else begin
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            if (boundary && pending_q) begin
                pending_q <= 1'b0;
            end
            if (accept) begin
                shadow_data_q <= load_data;
                shadow_dp_q   <= load_dp;
                pending_q     <= 1'b1;
            end
        end
    end

    always_comb begin
        active_data_d = active_data_q;
        active_dp_d   = active_dp_q;
        if (boundary && pending_q) begin
            active_data_d = shadow_data_q;
            active_dp_d   = shadow_dp_q;
        end
    end

    // Outputs are computed from next-cycle values so the registered pins line up with the FSM,
    // lighting the digit as soon as the dead-time count has run out.
    always_comb begin
        show   = (state_d == DRIVE) || (cnt_d == '0);
        nibble = active_data_d[{anode_index, 2'b00} +: 4];
        dp_bit = active_dp_d[anode_index];
        for (int i = 0; i < 4; i++) begin
            nib_zero[i] = (active_data_d[4*i +: 4] == 4'h0);
        end
        case (anode_index)
            2'd3:    lz_hit = nib_zero[3];
            2'd2:    lz_hit = &nib_zero[3:2];
            2'd1:    lz_hit = &nib_zero[3:1];
            default: lz_hit = 1'b0;
        endcase
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (show) begin
            an_d[anode_index] = 1'b0;
            seg_d = (LZ_EN && blank_lz && lz_hit) ? 7'h7F : hex_to_seg(nibble);
            dp_d  = ~dp_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: a cycle model pushes expected pin values
// into a scoreboard queue as each step is driven; they are popped after the edge.
module tb_sseg_scan_driver;

    localparam int DT = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk;
    logic        rst_n;
    logic [1:0]  anode_index;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  load_dp;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    sseg_scan_driver #(
        .DEADTIME (DT),
        .LZ_EN    (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .anode_index (anode_index),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_dp     (load_dp),
        .blank_lz    (blank_lz),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        int         step;
    } exp_t;

    exp_t sb_q[$];

    int assertions = 0;
    int failures   = 0;
    int step_no    = 0;

    logic [1:0]  m_idx;
    int          m_rem;
    logic [15:0] m_act_data, m_sh_data;
    logic [3:0]  m_act_dp, m_sh_dp;
    logic        m_pending;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkSignal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertions++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_idx      = 2'b11;
        m_rem      = (DT > 0) ? DT - 1 : 0;
        m_act_data = '0;
        m_act_dp   = '0;
        m_sh_data  = '0;
        m_sh_dp    = '0;
        m_pending  = 1'b0;
        sb_q.delete();
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb_q.size() == 0) begin
            assertions++;
            failures++;
            $error("[TB] FAIL scoreboard step %0d: observed empty queue expected entry", step_no);
        end else begin
            e = sb_q.pop_front();
            checkSignal("an", 16'(an), 16'(e.an));
            checkSignal("seg", 16'(seg), 16'(e.seg));
            checkSignal("dp", 16'(dp), 16'(e.dp));
        end
    endtask

    // One clock of stimulus: drive, check ready, advance model, push expectation, clock, pop.
    task automatic applyStimulus(input logic [1:0] idx, input logic valid,
                                 input logic [15:0] data, input logic [3:0] dpb,
                                 input logic lz);
        logic chg, bnd, acc, blank, sup;
        exp_t e;
        step_no++;
        anode_index = idx;
        load_valid  = valid;
        load_data   = data;
        load_dp     = dpb;
        blank_lz    = lz;
        #1;
        checkSignal("load_ready", 16'(load_ready), 16'(!m_pending));
        chg = (idx != m_idx);
        bnd = chg && (m_idx == 2'd0) && (idx == 2'd3);
        acc = valid && !m_pending;
        if (bnd && m_pending) begin
            m_act_data = m_sh_data;
            m_act_dp   = m_sh_dp;
            m_pending  = 1'b0;
        end
        if (acc) begin
            m_sh_data = data;
            m_sh_dp   = dpb;
            m_pending = 1'b1;
        end
        if (chg) m_rem = DT;
        blank = (m_rem > 0);
        if (m_rem > 0) m_rem--;
        m_idx = idx;
        e.step = step_no;
        if (blank) begin
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.an      = 4'hF;
            e.an[idx] = 1'b0;
            sup = lz && (idx != 2'd0);
            for (int k = int'(idx); k < 4; k++) begin
                if (m_act_data[4*k +: 4] != 4'h0) sup = 1'b0;
            end
            e.seg = sup ? 7'h7F : SEG_TAB[m_act_data[4*idx +: 4]];
            e.dp  = ~m_act_dp[idx];
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic holdIndex(input logic [1:0] idx, input int n, input logic lz);
        for (int i = 0; i < n; i++) applyStimulus(idx, 1'b0, 16'h0000, 4'h0, lz);
    endtask

    task automatic scanFrame(input logic lz);
        holdIndex(2'd2, 6, lz);
        holdIndex(2'd1, 6, lz);
        holdIndex(2'd0, 6, lz);
        holdIndex(2'd3, 6, lz);
    endtask

    task automatic pulseReset();
        #2;
        rst_n       = 1'b0;
        anode_index = 2'd3;
        load_valid  = 1'b0;
        #1;
        checkSignal("rst_an", 16'(an), 16'h000F);
        checkSignal("rst_seg", 16'(seg), 16'h007F);
        checkSignal("rst_dp", 16'(dp), 16'h0001);
        checkSignal("rst_ready", 16'(load_ready), 16'h0001);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        modelReset();
    endtask

    initial begin
        rst_n       = 1'b0;
        anode_index = 2'd3;
        load_valid  = 1'b0;
        load_data   = '0;
        load_dp     = '0;
        blank_lz    = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkSignal("init_an", 16'(an), 16'h000F);
        checkSignal("init_seg", 16'(seg), 16'h007F);
        checkSignal("init_dp", 16'(dp), 16'h0001);
        checkSignal("init_ready", 16'(load_ready), 16'h0001);
        rst_n = 1'b1;

        // Dead time after release, then digit 3 showing zero
        holdIndex(2'd3, 6, 1'b0);

        // Load applies only after the 0->3 frame boundary
        applyStimulus(2'd3, 1'b1, 16'h12AF, 4'b0100, 1'b0);
        holdIndex(2'd3, 1, 1'b0);
        scanFrame(1'b0);
        scanFrame(1'b0);

        // Second offer while pending is refused and its data dropped
        applyStimulus(2'd2, 1'b1, 16'h3456, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(2'd2, 1'b1, 16'h9999, 4'b1111, 1'b0);
        holdIndex(2'd2, 3, 1'b0);
        holdIndex(2'd1, 6, 1'b0);
        holdIndex(2'd0, 6, 1'b0);
        holdIndex(2'd3, 6, 1'b0);
        scanFrame(1'b0);

        // Load accepted on the boundary cycle waits a full frame
        holdIndex(2'd2, 6, 1'b0);
        holdIndex(2'd1, 6, 1'b0);
        holdIndex(2'd0, 6, 1'b0);
        applyStimulus(2'd3, 1'b1, 16'hBEEF, 4'b1000, 1'b0);
        holdIndex(2'd3, 5, 1'b0);
        scanFrame(1'b0);
        scanFrame(1'b0);

        // Back-to-back index changes restart the dead time
        applyStimulus(2'd2, 1'b0, 16'h0000, 4'h0, 1'b0);
        holdIndex(2'd2, 1, 1'b0);
        holdIndex(2'd1, 6, 1'b0);
        holdIndex(2'd0, 6, 1'b0);

        // Leading-zero blanking
        applyStimulus(2'd0, 1'b1, 16'h0007, 4'b0000, 1'b1);
        holdIndex(2'd3, 6, 1'b1);
        scanFrame(1'b1);
        applyStimulus(2'd3, 1'b1, 16'h0000, 4'b0010, 1'b1);
        scanFrame(1'b1);
        scanFrame(1'b1);

        // Reset while driving with a pending load discards everything
        holdIndex(2'd3, 2, 1'b0);
        applyStimulus(2'd3, 1'b1, 16'h1234, 4'hF, 1'b0);
        holdIndex(2'd3, 2, 1'b0);
        pulseReset();
        holdIndex(2'd3, 6, 1'b0);
        scanFrame(1'b0);
        scanFrame(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
